// File: rtl/trace_capture_buffer.sv
// Circular trace recorder for committed-instruction samples. A trigger arms a
// post-trigger window, and the frozen window is then streamed out oldest-first.
module trace_capture_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [1:0]               trig_mode,
  input  logic [DATA_W-1:0]        trig_value,
  input  logic                     force_trig,
  input  logic                     smp_valid,
  input  logic [DATA_W-1:0]        smp_pc,
  input  logic [DATA_W-1:0]        smp_instr,
  input  logic [DATA_W-1:0]        smp_adr,
  input  logic [DATA_W-1:0]        smp_wdata,
  input  logic                     smp_memwrite,
  input  logic [3:0]               smp_flags,
  output logic [1:0]               state,
  output logic                     triggered,
  output logic [$clog2(DEPTH):0]   fill_count,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [DATA_W-1:0]        rd_adr,
  output logic [DATA_W-1:0]        rd_wdata,
  output logic                     rd_memwrite,
  output logic [3:0]               rd_flags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
    logic              memwrite;
    logic [3:0]        flags;
  } entry_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] rd_cnt;
  logic [AW-1:0] rd_idx;
  logic          capturing;
  logic          mode_hit;
  logic          hit;
  logic          xfer;
  entry_t        mem [DEPTH];
  entry_t        rd_entry;

  assign state     = state_q;
  assign capturing = (state_q == S_ARMED || state_q == S_POST) && smp_valid;

  // Trigger qualification; only meaningful on a valid sample.
  always_comb begin
    mode_hit = 1'b0;
    case (trig_mode)
      2'd0:    mode_hit = (smp_pc == trig_value);
      2'd1:    mode_hit = smp_memwrite && (smp_adr == trig_value);
      2'd2:    mode_hit = (smp_instr == trig_value);
      default: mode_hit = 1'b0;
    endcase
    hit = smp_valid && (force_trig || mode_hit);
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (capturing) begin
      mem[wr_ptr] <= '{pc: smp_pc, instr: smp_instr, adr: smp_adr,
                       wdata: smp_wdata, memwrite: smp_memwrite, flags: smp_flags};
    end
  end

  // Oldest entry sits fill_count slots behind the write pointer.
  assign rd_idx   = wr_ptr - AW'(fill_count) + AW'(rd_cnt);
  assign rd_entry = mem[rd_idx];

  assign rd_valid    = (state_q == S_DONE) && (rd_cnt < fill_count);
  assign rd_last     = rd_valid && (rd_cnt == fill_count - CW'(1));
  assign rd_pc       = rd_entry.pc;
  assign rd_instr    = rd_entry.instr;
  assign rd_adr      = rd_entry.adr;
  assign rd_wdata    = rd_entry.wdata;
  assign rd_memwrite = rd_entry.memwrite;
  assign rd_flags    = rd_entry.flags;
  assign xfer        = rd_valid && rd_ready;

  // Capture/readout control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr     <= '0;
      fill_count <= '0;
      post_cnt   <= '0;
      rd_cnt     <= '0;
      triggered  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            post_cnt   <= '0;
            rd_cnt     <= '0;
            triggered  <= 1'b0;
            state_q    <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (smp_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (fill_count != CW'(DEPTH)) fill_count <= fill_count + CW'(1);
          end
          if (hit) begin
            triggered <= 1'b1;
            post_cnt  <= '0;
            state_q   <= (POST_TRIG == 0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          if (smp_valid) begin
            wr_ptr   <= wr_ptr + AW'(1);
            post_cnt <= post_cnt + CW'(1);
            if (fill_count != CW'(DEPTH)) fill_count <= fill_count + CW'(1);
            if (post_cnt + CW'(1) == CW'(POST_TRIG)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (arm) begin
            wr_ptr     <= '0;
            fill_count <= '0;
            post_cnt   <= '0;
            rd_cnt     <= '0;
            triggered  <= 1'b0;
            state_q    <= S_ARMED;
          end else if (xfer) begin
            if (rd_last) begin
              fill_count <= '0;
              rd_cnt     <= '0;
              state_q    <= S_IDLE;
            end else begin
              rd_cnt <= rd_cnt + CW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: DEPTH=8, POST_TRIG=3, hand-computed
// capture windows, trigger modes, valid gaps, backpressure, re-arm and reset.
module tb_trace_capture_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm;
  logic [1:0]        trig_mode;
  logic [DATA_W-1:0] trig_value;
  logic              force_trig;
  logic              smp_valid;
  logic [DATA_W-1:0] smp_pc, smp_instr, smp_adr, smp_wdata;
  logic              smp_memwrite;
  logic [3:0]        smp_flags;
  logic [1:0]        state;
  logic              triggered;
  logic [3:0]        fill_count;
  logic              rd_ready;
  logic              rd_valid, rd_last;
  logic [DATA_W-1:0] rd_pc, rd_instr, rd_adr, rd_wdata;
  logic              rd_memwrite;
  logic [3:0]        rd_flags;

  int errors = 0;
  int checks = 0;

  trace_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(3)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_mode(trig_mode),
    .trig_value(trig_value), .force_trig(force_trig), .smp_valid(smp_valid),
    .smp_pc(smp_pc), .smp_instr(smp_instr), .smp_adr(smp_adr),
    .smp_wdata(smp_wdata), .smp_memwrite(smp_memwrite), .smp_flags(smp_flags),
    .state(state), .triggered(triggered), .fill_count(fill_count),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_adr(rd_adr), .rd_wdata(rd_wdata),
    .rd_memwrite(rd_memwrite), .rd_flags(rd_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic feed(input logic [31:0] pc, input logic [31:0] adr,
                      input logic [31:0] wdata, input logic mw, input logic [3:0] fl);
    smp_valid    = 1'b1;
    smp_pc       = pc;
    smp_instr    = pc ^ 32'hE000_0000;
    smp_adr      = adr;
    smp_wdata    = wdata;
    smp_memwrite = mw;
    smp_flags    = fl;
    tick();
    smp_valid    = 1'b0;
    smp_memwrite = 1'b0;
  endtask

  // Drain a window whose PCs step by 4 from base; n entries expected.
  task automatic drain(input string tag, input logic [31:0] base, input int n);
    rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_pc"}, rd_pc, base + 32'(4 * i));
      chk({tag, "_last"}, 32'(rd_last), 32'(i == n - 1));
      tick();
    end
    rd_ready = 1'b0;
    chk({tag, "_idle"}, 32'(state), 32'd0);
    chk({tag, "_valid_after"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; arm = 1'b0; trig_mode = 2'd0; trig_value = '0; force_trig = 1'b0;
    smp_valid = 1'b0; smp_pc = '0; smp_instr = '0; smp_adr = '0; smp_wdata = '0;
    smp_memwrite = 1'b0; smp_flags = '0; rd_ready = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_trig", 32'(triggered), 32'd0);
    chk("rst_rdvalid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    tick();

    // Wrapped window: 12 samples into 8 slots, trigger at 0x20.
    trig_mode = 2'd0; trig_value = 32'h20;
    pulse_arm();
    chk("t1_armed", 32'(state), 32'd1);
    for (int i = 0; i < 12; i++) begin
      feed(32'(4 * i), 32'h0, 32'h0, 1'b0, 4'h0);
      if (i == 7) chk("t1_pretrig", 32'(triggered), 32'd0);
      if (i == 8) chk("t1_post", 32'(state), 32'd2);
      if (i == 10) chk("t1_still_post", 32'(state), 32'd2);
    end
    chk("t1_done", 32'(state), 32'd3);
    chk("t1_fill", 32'(fill_count), 32'd8);
    chk("t1_trig", 32'(triggered), 32'd1);
    feed(32'h80, 32'h0, 32'h0, 1'b0, 4'h0);
    chk("t1_frozen_fill", 32'(fill_count), 32'd8);
    drain("t1", 32'h10, 8);
    chk("t1_trig_held", 32'(triggered), 32'd1);

    // Early trigger: no wrap, readout from entry 0.
    trig_value = 32'h04;
    pulse_arm();
    chk("t2_trig_clr", 32'(triggered), 32'd0);
    for (int i = 0; i < 5; i++) feed(32'(4 * i), 32'h0, 32'h0, 1'b0, 4'h0);
    chk("t2_done", 32'(state), 32'd3);
    chk("t2_fill", 32'(fill_count), 32'd5);
    drain("t2", 32'h00, 5);

    // Store-address trigger requires memwrite.
    trig_mode = 2'd1; trig_value = 32'h64;
    pulse_arm();
    feed(32'h100, 32'h64, 32'h5, 1'b0, 4'h1);
    chk("t3_no_trig", 32'(triggered), 32'd0);
    chk("t3_armed", 32'(state), 32'd1);
    feed(32'h104, 32'h64, 32'h0000_0007, 1'b1, 4'hA);
    chk("t3_trig", 32'(triggered), 32'd1);
    for (int i = 0; i < 3; i++) feed(32'h108 + 32'(4 * i), 32'h0, 32'h0, 1'b0, 4'h0);
    chk("t3_done", 32'(state), 32'd3);
    chk("t3_fill", 32'(fill_count), 32'd5);
    chk("t3_e0_mw", 32'(rd_memwrite), 32'd0);
    chk("t3_e0_pc", rd_pc, 32'h100);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("t3_e1_pc", rd_pc, 32'h104);
    chk("t3_e1_mw", 32'(rd_memwrite), 32'd1);
    chk("t3_e1_wdata", rd_wdata, 32'h0000_0007);
    chk("t3_e1_adr", rd_adr, 32'h64);
    chk("t3_e1_flags", 32'(rd_flags), 32'hA);
    chk("t3_e1_instr", rd_instr, 32'hE000_0104);

    // Valid gaps in POST; arm in DONE aborts the readout.
    trig_mode = 2'd0; trig_value = 32'h08;
    pulse_arm();
    chk("t4_rearm", 32'(state), 32'd1);
    chk("t4_rearm_fill", 32'(fill_count), 32'd0);
    for (int i = 0; i < 4; i++) feed(32'(4 * i), 32'h0, 32'h0, 1'b0, 4'h0);
    smp_pc = 32'hDEAD;
    tick(); tick();
    chk("t4_gap_fill", 32'(fill_count), 32'd4);
    feed(32'h10, 32'h0, 32'h0, 1'b0, 4'h0);
    smp_pc = 32'h08;
    tick(); tick();
    chk("t4_gap_post", 32'(state), 32'd2);
    chk("t4_gap_fill2", 32'(fill_count), 32'd5);
    feed(32'h14, 32'h0, 32'h0, 1'b0, 4'h0);
    chk("t4_done", 32'(state), 32'd3);
    chk("t4_fill", 32'(fill_count), 32'd6);

    // Backpressure holds the head entry.
    for (int i = 0; i < 4; i++) begin
      chk("t5_hold_pc", rd_pc, 32'h00);
      chk("t5_hold_valid", 32'(rd_valid), 32'd1);
      tick();
    end
    rd_ready = 1'b1;
    tick();
    chk("t5_next_pc", rd_pc, 32'h04);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    rd_ready = 1'b0;
    chk("t5_arm_state", 32'(state), 32'd1);
    chk("t5_arm_fill", 32'(fill_count), 32'd0);
    chk("t5_arm_trig", 32'(triggered), 32'd0);
    chk("t5_arm_rdvalid", 32'(rd_valid), 32'd0);

    // Force-only mode, then async reset mid-POST.
    trig_mode = 2'd3; trig_value = 32'h40;
    feed(32'h40, 32'h40, 32'h0, 1'b1, 4'h0);
    chk("t6_no_trig", 32'(triggered), 32'd0);
    force_trig = 1'b1;
    feed(32'h44, 32'h0, 32'h0, 1'b0, 4'h0);
    force_trig = 1'b0;
    chk("t6_force", 32'(state), 32'd2);
    feed(32'h48, 32'h0, 32'h0, 1'b0, 4'h0);
    chk("t6_fill", 32'(fill_count), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_state", 32'(state), 32'd0);
    chk("t6_rst_fill", 32'(fill_count), 32'd0);
    chk("t6_rst_trig", 32'(triggered), 32'd0);
    chk("t6_rst_rdvalid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    tick();
    chk("t6_after_rst", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
